// File: rtl/gw2a_ddr_rdalign.sv
// gw2a_ddr_rdalign: multi-lane read-capture aligner for the GW2A DDR PHY.
// Runs in the PCLK domain behind a bank of IDES4 deserialisers. Each lane
// picks one of four sample-pair/bit-order candidates. The pick can be
// written directly or found at run time by a calibration sweep. The sweep
// checks every candidate against a fixed training pair.
// Optional feature: define GW2A_RDALIGN_MASK_EN to add the CALIB_MASK output.
// That output holds the per-lane pass mask of the last calibration.
`timescale 1ns/1ps

module gw2a_ddr_rdalign #(
    parameter int         WIDTH         = 16,
    parameter logic       DELAY         = 1'b0,
    parameter logic [1:0] PATTERN       = 2'b10,
    parameter int         SETTLE        = 4,
    parameter int         CAL_CYCLES    = 16,
    parameter logic [1:0] DEFAULT_SHIFT = 2'b00
) (
    input  logic                 PCLK,
    input  logic                 RESET,
    input  logic [4*WIDTH-1:0]   DI,
    input  logic                 CALIB_REQ,
    input  logic                 SHIFT_WR,
    input  logic [2*WIDTH-1:0]   SHIFT_WDATA,
    output logic [WIDTH-1:0]     Q0,
    output logic [WIDTH-1:0]     Q1,
    output logic [2*WIDTH-1:0]   SHIFT_O,
    output logic                 CALIB_BUSY,
    output logic                 CALIB_DONE,
    output logic [WIDTH-1:0]     CALIB_FAIL
`ifdef GW2A_RDALIGN_MASK_EN
    ,
    output logic [4*WIDTH-1:0]   CALIB_MASK
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_RESOLVE
    } state_e;

    // One shared counter times both the settle and the check windows.
    localparam int CNT_MAX = (SETTLE > CAL_CYCLES) ? SETTLE : CAL_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CHECK_LAST  = CNT_W'(CAL_CYCLES - 1);

    // Candidate s maps the raw lane samples {d3,d2,d1,d0} to {b,a}.
    function automatic logic [1:0] pick(input logic [3:0] d, input logic [1:0] s);
        logic [1:0] ba;
        unique case (s)
            2'd0:    ba = {d[2], d[0]};
            2'd1:    ba = {d[3], d[1]};
            2'd2:    ba = {d[0], d[2]};
            default: ba = {d[1], d[3]};
        endcase
        return ba;
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         cand_q, cand_d;
    logic               start, check_exit, resolve, enter_settle;
    logic               busy, out_zero;

    logic [2*WIDTH-1:0] shift_q;
    logic [WIDTH-1:0]   fail_q;
    logic               done_q;
    logic [WIDTH-1:0]   ok_q, ok_d, ok_chk;
    logic [WIDTH-1:0]   a_c, b_c, match_c;
    logic [1:0]         pair_c;
    logic [WIDTH-1:0]   q0_q, q1_q, bprev_q;
    logic [WIDTH-1:0]   res_found;
    logic [2*WIDTH-1:0] res_shift;

    assign busy         = (state_q != ST_IDLE);
    assign enter_settle = (state_d == ST_SETTLE) && (state_q != ST_SETTLE);
    // Outputs are zero during the sweep and in the DONE cycle. The new
    // shift therefore appears on Q0/Q1 in a single clean step.
    assign out_zero     = busy || (state_d != ST_IDLE);

    // Calibration sequencer: next state, window counter and candidate index.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it unassigned (which would infer a latch).
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        start      = 1'b0;
        check_exit = 1'b0;
        resolve    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // A request arriving in the DONE cycle is ignored.
                if (CALIB_REQ && !done_q) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                    cand_d  = 2'd0;
                    start   = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CHECK: begin
                if (cnt_q == CHECK_LAST) begin
                    check_exit = 1'b1;
                    cnt_d      = '0;
                    if (cand_q == 2'd3) begin
                        state_d = ST_RESOLVE;
                    end else begin
                        state_d = ST_SETTLE;
                        cand_d  = cand_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESOLVE: begin
                state_d = ST_IDLE;
                resolve = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge PCLK or posedge RESET) begin
        // NOTE: non-blocking assignments let every register sample pre-edge values, matching real flops.
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cand_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    // Per-lane pair selection and training-pattern compare. During the
    // sweep all lanes use the shared candidate instead of their own shift.
    always_comb begin
        a_c     = '0;
        b_c     = '0;
        match_c = '0;
        pair_c  = 2'b00;
        for (int i = 0; i < WIDTH; i++) begin
            pair_c     = pick(DI[4*i +: 4], busy ? cand_q : shift_q[2*i +: 2]);
            a_c[i]     = pair_c[0];
            b_c[i]     = pair_c[1];
            match_c[i] = (pair_c == PATTERN);
        end
        ok_chk = ok_q & match_c;
        if (enter_settle) begin
            ok_d = '1;
        end else if (state_q == ST_CHECK) begin
            ok_d = ok_chk;
        end else begin
            ok_d = ok_q;
        end
    end

`ifdef GW2A_RDALIGN_MASK_EN
    logic [WIDTH-1:0][3:0] mask_q;
    logic [4*WIDTH-1:0]    calib_mask_q;

    // Lowest-index passing candidate from the full per-lane mask.
    always_comb begin
        res_found = '0;
        res_shift = '0;
        for (int i = 0; i < WIDTH; i++) begin
            res_found[i] = |mask_q[i];
            if (mask_q[i][0])      res_shift[2*i +: 2] = 2'd0;
            else if (mask_q[i][1]) res_shift[2*i +: 2] = 2'd1;
            else if (mask_q[i][2]) res_shift[2*i +: 2] = 2'd2;
            else                   res_shift[2*i +: 2] = 2'd3;
        end
    end

    // Record each candidate's verdict and publish the mask at completion.
    always_ff @(posedge PCLK or posedge RESET) begin
        // NOTE: the mask storage is reset because its value is architecturally visible after reset, not just scratch.
        if (RESET) begin
            mask_q       <= '0;
            calib_mask_q <= '0;
        end else begin
            if (check_exit) begin
                for (int i = 0; i < WIDTH; i++) begin
                    mask_q[i][cand_q] <= ok_chk[i];
                end
            end
            if (resolve) begin
                calib_mask_q <= mask_q;
            end
        end
    end

    assign CALIB_MASK = calib_mask_q;
`else
    logic [WIDTH-1:0]   found_q;
    logic [2*WIDTH-1:0] best_q;

    // Keep only the first (lowest) passing candidate per lane. Candidates
    // are swept in ascending order, so the first pass is the lowest.
    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            found_q <= '0;
            best_q  <= '0;
        end else if (start) begin
            found_q <= '0;
        end else if (check_exit) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (ok_chk[i] && !found_q[i]) begin
                    found_q[i]        <= 1'b1;
                    best_q[2*i +: 2]  <= cand_q;
                end
            end
        end
    end

    assign res_found = found_q;
    assign res_shift = best_q;
`endif

    // Per-lane ok flags, shift registers, fail flags and completion pulse.
    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            ok_q    <= '0;
            shift_q <= {WIDTH{DEFAULT_SHIFT}};
            fail_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            ok_q   <= ok_d;
            done_q <= resolve;
            if (resolve) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (res_found[i]) begin
                        shift_q[2*i +: 2] <= res_shift[2*i +: 2];
                        fail_q[i]         <= 1'b0;
                    end else begin
                        fail_q[i]         <= 1'b1;
                    end
                end
            end else if ((state_q == ST_IDLE) && SHIFT_WR && !start) begin
                // A direct write loses to a calibration request in the same cycle.
                shift_q <= SHIFT_WDATA;
            end
        end
    end

    // Aligned output pair. With DELAY set, Q0 carries the previous cycle's
    // second bit, so the pair straddles two PCLK cycles.
    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            q0_q    <= '0;
            q1_q    <= '0;
            bprev_q <= '0;
        end else if (out_zero) begin
            q0_q    <= '0;
            q1_q    <= '0;
            bprev_q <= '0;
        end else if (DELAY) begin
            q0_q    <= bprev_q;
            q1_q    <= a_c;
            bprev_q <= b_c;
        end else begin
            q0_q    <= a_c;
            q1_q    <= b_c;
            bprev_q <= b_c;
        end
    end

    assign Q0         = q0_q;
    assign Q1         = q1_q;
    assign SHIFT_O    = shift_q;
    assign CALIB_BUSY = busy;
    assign CALIB_DONE = done_q;
    assign CALIB_FAIL = fail_q;

endmodule

// File: tb/tb_gw2a_ddr_rdalign.sv
// Bench for gw2a_ddr_rdalign with two lanes and DEFAULT_SHIFT=11.
// The stimulus pushes the expected calibration result into a queue. A
// monitor pops from that queue and compares on every CALIB_DONE pulse.
`timescale 1ns/1ps

module tb_gw2a_ddr_rdalign;

    localparam int W      = 2;
    localparam int N_BUSY = 4 * (4 + 16) + 1;

    logic           pclk = 1'b0;
    logic           rst;
    logic [4*W-1:0] di;
    logic           calib_req;
    logic           shift_wr;
    logic [2*W-1:0] shift_wdata;
    logic [W-1:0]   q0, q1;
    logic [2*W-1:0] shift_o;
    logic           calib_busy, calib_done;
    logic [W-1:0]   calib_fail;
`ifdef GW2A_RDALIGN_MASK_EN
    logic [4*W-1:0] calib_mask;
`endif

    typedef struct packed {
        logic [3:0] shift;
        logic [1:0] fail;
        logic [7:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_pass     = 0;
    int   done_count = 0;
    int   busy_run   = 0;

    gw2a_ddr_rdalign #(
        .WIDTH        (W),
        .DELAY        (1'b0),
        .PATTERN      (2'b10),
        .SETTLE       (4),
        .CAL_CYCLES   (16),
        .DEFAULT_SHIFT(2'b11)
    ) dut (
        .PCLK       (pclk),
        .RESET      (rst),
        .DI         (di),
        .CALIB_REQ  (calib_req),
        .SHIFT_WR   (shift_wr),
        .SHIFT_WDATA(shift_wdata),
        .Q0         (q0),
        .Q1         (q1),
        .SHIFT_O    (shift_o),
        .CALIB_BUSY (calib_busy),
        .CALIB_DONE (calib_done),
        .CALIB_FAIL (calib_fail)
`ifdef GW2A_RDALIGN_MASK_EN
        ,
        .CALIB_MASK (calib_mask)
`endif
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_exp(input logic [3:0] s, input logic [1:0] f, input logic [7:0] m);
        exp_t e;
        e.shift = s;
        e.fail  = f;
        e.mask  = m;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; the request is sampled on the next edge.
    task automatic pulse_req();
        calib_req = 1'b1;
        @(posedge pclk); #1;
        calib_req = 1'b0;
    endtask

    // Returns at the falling edge inside the DONE cycle (bounded wait).
    task automatic wait_done();
        int k = 0;
        @(negedge pclk);
        while (!calib_done && k < 300) begin
            @(negedge pclk);
            k++;
        end
        check("done_seen", calib_done, 1);
    endtask

    // Monitor: scores each completion against the queued expectation.
    always @(negedge pclk) begin
        if (rst) begin
            busy_run = 0;
        end else begin
            if (calib_done) begin
                exp_t e;
                done_count++;
                check("done_busy_low", calib_busy, 0);
                check("busy_len", busy_run, N_BUSY);
                check("done_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("cal_shift", shift_o, e.shift);
                    check("cal_fail", calib_fail, e.fail);
`ifdef GW2A_RDALIGN_MASK_EN
                    check("cal_mask", calib_mask, e.mask);
`endif
                end
            end
            if (calib_busy) busy_run++;
            else busy_run = 0;
        end
    end

    initial begin
        rst         = 1'b1;
        di          = {4'b1000, 4'b1000};
        calib_req   = 1'b0;
        shift_wr    = 1'b0;
        shift_wdata = '0;

        // Reset state
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("rst_shift", shift_o, 4'b1111);
        check("rst_q0", q0, 0);
        check("rst_q1", q1, 0);
        check("rst_busy", calib_busy, 0);
        check("rst_done", calib_done, 0);
        check("rst_fail", calib_fail, 0);
`ifdef GW2A_RDALIGN_MASK_EN
        check("rst_mask", calib_mask, 0);
`endif
        @(posedge pclk); #1;
        rst = 1'b0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        check("post_rst_q0", q0, 2'b11);
        check("post_rst_q1", q1, 2'b00);

        // Basic calibration: lane0 -> cand 0, lane1 -> cand 1
        @(posedge pclk); #1;
        di = {4'b1000, 4'b0100};
        push_exp(4'b0100, 2'b00, 8'h21);
        pulse_req();
        @(negedge pclk);
        check("busy_high", calib_busy, 1);
        check("busy_q0_zero", q0, 0);
        check("busy_q1_zero", q1, 0);
        wait_done();
        @(negedge pclk);
        check("done_one_cycle", calib_done, 0);
        check("new_q0", q0, 2'b00);
        check("new_q1", q1, 2'b11);

        // Direct write, then a calibration where lane1 never passes
        @(posedge pclk); #1;
        shift_wr    = 1'b1;
        shift_wdata = 4'b1101;
        @(posedge pclk); #1;
        shift_wr = 1'b0;
        @(negedge pclk);
        check("wr_shift", shift_o, 4'b1101);
        check("wr_fail_kept", calib_fail, 2'b00);
        @(posedge pclk); #1;
        di = {4'b0000, 4'b0100};
        push_exp(4'b1100, 2'b10, 8'h01);
        pulse_req();
        wait_done();

        // Glitch rejection: one bad cycle in cand 0's check window on lane0
        @(posedge pclk); #1;
        di = {4'b1000, 4'b1100};
        push_exp(4'b0101, 2'b00, 8'h22);
        pulse_req();
        repeat (9) @(posedge pclk);
        #1;
        di[3:0] = 4'b0000;
        @(posedge pclk); #1;
        di[3:0] = 4'b1100;
        wait_done();

        // Collisions: write with the request, write and request during busy,
        // request during the DONE cycle
        @(posedge pclk); #1;
        di = {4'b1000, 4'b0100};
        push_exp(4'b0100, 2'b00, 8'h21);
        shift_wr    = 1'b1;
        shift_wdata = 4'b1010;
        calib_req   = 1'b1;
        @(posedge pclk); #1;
        calib_req = 1'b0;
        repeat (4) @(posedge pclk);
        #1;
        calib_req = 1'b1;
        @(posedge pclk); #1;
        calib_req = 1'b0;
        shift_wr  = 1'b0;
        wait_done();
        calib_req = 1'b1;
        @(posedge pclk); #1;
        calib_req = 1'b0;
        @(negedge pclk);
        check("done_req_ignored", calib_busy, 0);
        check("busy_wr_dropped", shift_o, 4'b0100);

        // Reset at cycle 40 of a calibration, then a clean run
        @(posedge pclk); #1;
        pulse_req();
        repeat (39) @(posedge pclk);
        #1;
        rst = 1'b1;
        @(negedge pclk);
        check("midrst_busy", calib_busy, 0);
        check("midrst_shift", shift_o, 4'b1111);
        check("midrst_done", calib_done, 0);
        check("midrst_q0", q0, 0);
        @(posedge pclk); #1;
        rst = 1'b0;
        @(posedge pclk); #1;
        push_exp(4'b0100, 2'b00, 8'h21);
        pulse_req();
        wait_done();

        repeat (5) @(negedge pclk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("done_count", done_count, 5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gw2a_ddr_rdalign.md
# gw2a_ddr_rdalign

Multi-lane read-capture aligner for the GW2A DDR PHY. Sits in the PCLK domain after a bank of IDES4 deserialisers (4 raw samples per lane per PCLK). Per lane, it selects a sample pair and bit order from 4 candidates and calibrates each lane's selection at run time against a training pattern. The per-lane selection can also be written directly. This replaces the fixed compile-time sample-shift selection with a per-lane, run-time-calibrated one.

## Interface
- WIDTH, 16, number of lanes
- DELAY, 1'b0, global: 1 = output pair straddles PCLK cycles (Q0 = previous cycle's second bit)
- PATTERN, 2'b10, expected training pair {Q1,Q0} on every lane, every cycle
- SETTLE, 4, cycles discarded after each candidate change (≥2)
- CAL_CYCLES, 16, consecutive matching cycles a candidate needs to pass (≥1)
- DEFAULT_SHIFT, 2'b00, per-lane shift after reset
- PCLK  in  1  bus clock; all logic is on the rising edge
- RESET  in  1  asynchronous, active-high
- DI  in  4*WIDTH  raw samples; lane i = DI[4i+3:4i] = {d3,d2,d1,d0}
- CALIB_REQ  in  1  start calibration; sampled only in IDLE
- SHIFT_WR  in  1  load SHIFT_WDATA into all lane shifts; IDLE only
- SHIFT_WDATA  in  2*WIDTH  lane i = [2i+1:2i]
- Q0, Q1  out  WIDTH each  aligned DDR bit pair per lane
- SHIFT_O  out  2*WIDTH  current per-lane shift
- CALIB_BUSY  out  1  calibration in progress
- CALIB_DONE  out  1  one-cycle pulse when calibration completes
- CALIB_FAIL  out  WIDTH  lane had no passing candidate in the last calibration

## Operation
- Per-lane selection for shift s gives the pair {a,b}:
  - 00 → {d0,d2}
  - 01 → {d1,d3}
  - 10 → {d2,d0}
  - 11 → {d3,d1}
- Output registers (1-cycle latency):
  - DELAY=0: Q0<=a, Q1<=b.
  - DELAY=1: Q0<=b registered from the previous cycle, Q1<=a.
- FSM states: IDLE → SETTLE → CHECK → (next candidate: SETTLE | last: RESOLVE) → IDLE.
- Candidate counter cand runs 0..3 and is shared by all lanes.
  - While BUSY, every lane's selection uses cand, not SHIFT_O.
- SETTLE: SETTLE cycles. On entry, per-lane ok flags are set to 1.
- CHECK: CAL_CYCLES cycles.
  - ok[i] clears on any cycle where lane i's combinational {b,a} ≠ PATTERN.
  - On exit, ok[i] is stored into mask[i][cand].
- RESOLVE: one cycle.
  - Each lane takes its lowest-index passing candidate.
  - A lane with no passing candidate keeps its prior SHIFT_O and sets CALIB_FAIL[i]=1; otherwise CALIB_FAIL[i]=0.
- While BUSY, Q0/Q1 are forced to 0.
- SHIFT_WR in IDLE: SHIFT_O <= SHIFT_WDATA on the next edge. CALIB_FAIL is unchanged.

## Timing
- Reset values:
  - Q0=Q1=0, SHIFT_O={WIDTH{DEFAULT_SHIFT}}
  - CALIB_BUSY=0, CALIB_DONE=0, CALIB_FAIL=0, mask=0
  - FSM in IDLE
- CALIB_REQ high in IDLE at cycle t: CALIB_BUSY=1 over cycles t+1 … t+N, where N=4*(SETTLE+CAL_CYCLES)+1.
- At cycle t+N+1:
  - CALIB_DONE=1 for one cycle and CALIB_BUSY=0.
  - SHIFT_O and CALIB_FAIL show the new values.
- Q0/Q1 reflect the new shift from cycle t+N+2.
- CALIB_REQ while BUSY or in the DONE cycle: ignored.
- SHIFT_WR while BUSY: dropped.
- CALIB_REQ and SHIFT_WR in the same IDLE cycle: calibration wins; the write is dropped.
- RESET asserted mid-calibration: all state returns to reset values immediately; no CALIB_DONE.

## Configuration
- GW2A_RDALIGN_MASK_EN defined:
  - Adds output CALIB_MASK [4*WIDTH-1:0]; lane i = [4i+3:4i], bit c = candidate c passed.
  - Updated in the CALIB_DONE cycle; reset value 0; holds until the next completion.
- Not defined:
  - Port absent.
  - Only the running lowest-pass index is kept per lane; no 4-bit masks are stored.
  - Every other output behaves identically.

## Test plan
- Reset: hold RESET 3 cycles with DEFAULT_SHIFT=2'b11 → SHIFT_O=all 11, all outputs 0; DI=4'b1000 on all lanes → after 2 cycles Q0=1, Q1=0.
- Calibration, WIDTH=2, PATTERN=2'b10, lane0 DI=4'b0100, lane1 DI=4'b1000, pulse CALIB_REQ:
  - BUSY lasts exactly 81 cycles, then a one-cycle DONE pulse.
  - SHIFT_O=4'b0100, CALIB_FAIL=2'b00; with the macro, CALIB_MASK=8'h21.
- Fail case: lane1 DI=4'b0000 with a prior SHIFT_WR value of 2'b11 → CALIB_FAIL=2'b10, lane1 shift stays 11, lane0=00.
- Glitch rejection: lane0 mismatches for 1 cycle inside cand 0's CHECK window → lane0 does not pass cand 0; the result is the next passing candidate, or FAIL.
- Collisions: SHIFT_WR in the CALIB_REQ cycle and during BUSY → write ignored; a second CALIB_REQ during BUSY → exactly one DONE pulse.
- Reset mid-calibration at cycle 40 → BUSY=0, SHIFT_O=DEFAULT_SHIFT, no DONE; a new CALIB_REQ completes normally.
